// File: rtl/data_mem_responder.sv
// Data-memory responder for the CPU MEM stage: clears itself after reset,
// then serves single-cycle stores and same-cycle (asynchronous) loads over a
// shared bidirectional 64-bit bus, with a sticky error flag and access counters.
module data_mem_responder #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      mem_addr,
    input  logic             mem_rw,
    input  logic             mem_rd,
    inout  wire  [63:0]      mem_data,
    output logic             ready,
    output logic             err,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_idx;
    logic [63:0]         r_mem [DEPTH];

    logic [ADDR_W-1:0]   w_idx;
    logic                w_misaligned;
    logic                w_out_of_range;
    logic                w_bad;
    logic                w_in_ready;
    logic                w_store_ok;
    logic                w_load_ok;
    logic                w_drive;
    logic                w_err_evt;
    logic [63:0]         w_rd_data;

    // Address decode and access qualification
    assign w_idx          = mem_addr[ADDR_W+2:3];
    assign w_misaligned   = |mem_addr[2:0];
    assign w_out_of_range = |mem_addr[63:ADDR_W+3];
    assign w_bad          = w_misaligned | w_out_of_range;
    assign w_in_ready     = (r_state == ST_READY);
    assign w_store_ok     = w_in_ready & mem_rw & ~w_bad;
    assign w_load_ok      = w_in_ready & mem_rd & ~mem_rw & ~w_bad;

    // During the sweep any access is a protocol error; once ready, bad
    // addresses and simultaneous load+store are errors.
    assign w_err_evt = w_in_ready ? (((mem_rw | mem_rd) & w_bad) | (mem_rw & mem_rd))
                                  : (mem_rw | mem_rd);

    // Bus is driven only for a pure load; unserviceable loads return zero
    assign w_drive   = ~rst & mem_rd & ~mem_rw;
    assign w_rd_data = w_load_ok ? r_mem[w_idx] : 64'h0;
    assign mem_data  = w_drive ? w_rd_data : 64'hz;

    // Storage writes: clearing sweep while initialising, CPU stores once ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_INIT) begin
                r_mem[r_idx] <= 64'h0;
            end else if (w_store_ok) begin
                r_mem[w_idx] <= mem_data;
            end
        end
    end

    // Control FSM, sweep index, status flags and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_idx     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            load_cnt  <= '0;
            store_cnt <= '0;
        end else begin
            if (w_err_evt) begin
                err <= 1'b1;
            end
            case (r_state)
                ST_INIT: begin
                    r_idx <= r_idx + ADDR_W'(1);
                    if (&r_idx) begin
                        r_state <= ST_READY;
                        ready   <= 1'b1;
                    end
                end
                ST_READY: begin
                    ready <= 1'b1;
                    if (w_store_ok) begin
                        store_cnt <= store_cnt + CNT_W'(1);
                    end
                    if (w_load_ok) begin
                        load_cnt <= load_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (ADDR_W=4): sweep timing, access
// vectors applied from a table, and a reset issued part-way through the sweep.
module tb_data_mem_responder;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned NVEC   = 16;

    logic             clk;
    logic             rst;
    logic [63:0]      mem_addr;
    logic             mem_rw;
    logic             mem_rd;
    wire  [63:0]      mem_data;
    logic             ready;
    logic             err;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] store_cnt;

    logic             cpu_oe;
    logic [63:0]      cpu_data;

    int n_tests;
    int n_fail;

    assign mem_data = cpu_oe ? cpu_data : 64'hz;

    data_mem_responder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_rw    (mem_rw),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .ready     (ready),
        .err       (err),
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        rd;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        chk_bus;
        logic [63:0] exp_bus;
        logic        exp_err;
        logic [31:0] exp_ld;
        logic [31:0] exp_st;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        mem_rw   = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = 64'h0;
        cpu_oe   = 1'b0;
        cpu_data = 64'h0;
    endtask

    // Holds rst for n posedges; returns just after the negedge that releases it
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        drive_idle();

        // vector table: {rw, rd, addr, wdata, chk_bus, exp_bus, exp_err, exp_ld, exp_st}
        vecs[0]  = '{1'b1, 1'b0, 64'h18, 64'hDEADBEEF01234567, 1'b0, 64'h0,               1'b0, 32'd0, 32'd1};
        vecs[1]  = '{1'b0, 1'b1, 64'h18, 64'h0,               1'b1, 64'hDEADBEEF01234567, 1'b0, 32'd1, 32'd1};
        vecs[2]  = '{1'b1, 1'b0, 64'h20, 64'h00000000CAFEF00D, 1'b0, 64'h0,               1'b0, 32'd1, 32'd2};
        vecs[3]  = '{1'b0, 1'b1, 64'h20, 64'h0,               1'b1, 64'h00000000CAFEF00D, 1'b0, 32'd2, 32'd2};
        vecs[4]  = '{1'b0, 1'b1, 64'h18, 64'h0,               1'b1, 64'hDEADBEEF01234567, 1'b0, 32'd3, 32'd2};
        vecs[5]  = '{1'b1, 1'b0, 64'h1C, 64'h1,               1'b0, 64'h0,               1'b1, 32'd3, 32'd2};
        vecs[6]  = '{1'b0, 1'b1, 64'h18, 64'h0,               1'b1, 64'hDEADBEEF01234567, 1'b1, 32'd4, 32'd2};
        vecs[7]  = '{1'b0, 1'b1, 64'h80, 64'h0,               1'b1, 64'h0,               1'b1, 32'd4, 32'd2};
        vecs[8]  = '{1'b1, 1'b0, 64'h08, 64'hFF00FF00FF00FF00, 1'b0, 64'h0,               1'b1, 32'd4, 32'd3};
        vecs[9]  = '{1'b1, 1'b1, 64'h08, 64'hA5,              1'b1, 64'hA5,              1'b1, 32'd4, 32'd4};
        vecs[10] = '{1'b0, 1'b1, 64'h08, 64'h0,               1'b1, 64'hA5,              1'b1, 32'd5, 32'd4};
        vecs[11] = '{1'b0, 1'b1, 64'h78, 64'h0,               1'b1, 64'h0,               1'b1, 32'd6, 32'd4};
        vecs[12] = '{1'b1, 1'b0, 64'h78, 64'h1234,            1'b0, 64'h0,               1'b1, 32'd6, 32'd5};
        vecs[13] = '{1'b0, 1'b1, 64'h78, 64'h0,               1'b1, 64'h1234,            1'b1, 32'd7, 32'd5};
        vecs[14] = '{1'b0, 1'b1, 64'h19, 64'h0,               1'b1, 64'h0,               1'b1, 32'd7, 32'd5};
        vecs[15] = '{1'b0, 1'b0, 64'h78, 64'h0,               1'b0, 64'h0,               1'b1, 32'd7, 32'd5};

        // Reset state after two reset cycles
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_load_cnt", 64'(load_cnt), 64'h0);
        chk("rst_store_cnt", 64'(store_cnt), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sweep: ready low for 15 posedges, high after the 16th; load during sweep
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sweep_ready_%0d", k), 64'(ready), (k == 16) ? 64'h1 : 64'h0);
            if (k == 4) chk("sweep_err_before", 64'(err), 64'h0);
            if (k == 5) begin
                chk("sweep_err_after_load", 64'(err), 64'h1);
                chk("sweep_load_cnt", 64'(load_cnt), 64'h0);
            end
            @(negedge clk);
            drive_idle();
            if (k == 4) begin
                mem_rd   = 1'b1;
                mem_addr = 64'h40;
                #1;
                chk("sweep_load_bus", mem_data, 64'h0);
            end
        end

        // Clean reset, then table-driven accesses
        do_reset(2);
        repeat (16) @(posedge clk);
        #1;
        chk("clean_ready", 64'(ready), 64'h1);
        chk("clean_err", 64'(err), 64'h0);

        for (int i = 0; i < int'(NVEC); i++) begin
            @(negedge clk);
            mem_rw   = vecs[i].rw;
            mem_rd   = vecs[i].rd;
            mem_addr = vecs[i].addr;
            cpu_oe   = vecs[i].rw;
            cpu_data = vecs[i].wdata;
            #1;
            if (vecs[i].chk_bus) chk($sformatf("vec%0d_bus", i), mem_data, vecs[i].exp_bus);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_load_cnt", i), 64'(load_cnt), 64'(vecs[i].exp_ld));
            chk($sformatf("vec%0d_store_cnt", i), 64'(store_cnt), 64'(vecs[i].exp_st));
        end
        @(negedge clk);
        drive_idle();

        // Reset part-way through the sweep (index 7): sweep restarts from 0
        do_reset(1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k >= 14) chk($sformatf("resweep_ready_%0d", k), 64'(ready), (k == 16) ? 64'h1 : 64'h0);
        end
        chk("resweep_err", 64'(err), 64'h0);

        // Previously written location is cleared by the new sweep
        @(negedge clk);
        mem_rd   = 1'b1;
        mem_addr = 64'h18;
        #1;
        chk("resweep_load_bus", mem_data, 64'h0);
        @(posedge clk);
        #1;
        chk("resweep_load_cnt", 64'(load_cnt), 64'h1);
        chk("resweep_err_after", 64'(err), 64'h0);
        @(negedge clk);
        drive_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the CPU's MEM stage; the slave end of the CPU's memory interface.
- Inputs: byte address (EX_MEM result), store strobe (EX_MEM mem_rw), load strobe (EX_MEM is_load).
- The CPU drives the shared 64-bit bidirectional data bus on stores. This block drives the bus on loads, with data valid in the same cycle so the CPU latches it into MEM/WB.
- Includes a post-reset clearing sweep, sticky protocol-error flag and access counters.

Parameters:
- ADDR_W, 10, doubleword index width; depth = 2^ADDR_W entries of 64 bits.
- CNT_W, 32, width of load/store counters.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_addr  input  64  byte address; bits [2:0] must be 0
- mem_rw  input  1  1 = store this cycle; CPU drives mem_data
- mem_rd  input  1  1 = load this cycle; responder drives mem_data
- mem_data  inout  64  shared data bus
- ready  output  1  1 = clearing sweep done, accesses honoured
- err  output  1  sticky protocol/address error flag
- load_cnt  output  CNT_W  honoured loads since reset
- store_cnt  output  CNT_W  honoured stores since reset

Behaviour:
- Reset (rst=1 at posedge):
  - state<=INIT, sweep index<=0, ready=0, err=0, load_cnt=0, store_cnt=0.
  - mem_data not driven (Z) while rst=1.
- FSM INIT:
  - Each posedge with rst=0 writes 64'h0 to entry[index], then index++.
  - After the posedge writing entry[2^ADDR_W-1], state<=READY.
  - ready=1 from that cycle on: exactly 2^ADDR_W posedges after rst deasserts.
- In INIT:
  - CPU stores are dropped.
  - Loads: bus driven with 64'h0, combinationally while mem_rd=1 and mem_rw=0.
  - Counters unchanged.
  - Any mem_rw or mem_rd asserted during INIT sets err.
- FSM READY:
  - Stays READY until rst.
  - No other transitions; a new sweep happens only via rst.
- Address decode:
  - idx = mem_addr[ADDR_W+2:3].
  - misaligned = |mem_addr[2:0].
  - out_of_range = |mem_addr[63:ADDR_W+3].
  - bad = misaligned | out_of_range.
- Store (READY, mem_rw=1, mem_rd=0, !bad):
  - entry[idx] <= mem_data at posedge; store_cnt++.
  - Responder never drives the bus.
- Load (READY, mem_rd=1, mem_rw=0, !bad):
  - mem_data = entry[idx] combinationally (asynchronous read), same cycle; load_cnt increments at posedge.
  - Read-after-write: a store at cycle N is visible to a load at cycle N+1. A load in cycle N sees pre-store contents.
- Bad address:
  - Store is ignored.
  - Load drives 64'h0 on the bus.
  - err set at posedge; counters unchanged.
- mem_rw=1 and mem_rd=1 together:
  - Store performed if !bad and READY.
  - Responder does not drive the bus (no contention).
  - err set; store_cnt++ only if the store was honoured; load_cnt unchanged.
- Bus drive rule:
  - Responder drives mem_data only when rst=0, mem_rd=1, mem_rw=0; otherwise Z.
- Counters wrap modulo 2^CNT_W.
- err remains 1 until rst.
- rst mid-sweep: sweep restarts at index 0; ready stays 0 for a full 2^ADDR_W posedges after release.
- rst in READY: all contents re-cleared by the new sweep.

Test Plan:
- ADDR_W=4. Hold rst 2 cycles, release -> ready=0 for 16 posedges, 1 after the 16th. Load at 0x40 during sweep -> bus=0, err=1.
- After reset with err=0 and ready=1: store 0x18 data 64'hDEADBEEF01234567, next cycle load 0x18 -> bus=64'hDEADBEEF01234567 in the load cycle; store_cnt=1, load_cnt=1, err=0.
- Misaligned store to 0x1C data 64'h1 -> no write, err=1. Load 0x18 still returns 64'hDEADBEEF01234567; store_cnt unchanged.
- Load 0x80 (out of range for ADDR_W=4) -> bus=64'h0, err=1, load_cnt unchanged.
- mem_rw=1, mem_rd=1, addr 0x08, CPU drives 64'hA5 -> responder output Z, entry[1]=64'hA5 (next load 0x08 returns 64'hA5), store_cnt+1, err=1.
- Assert rst when sweep index=7 -> index restarts at 0; ready rises 16 posedges after release. Previously written 0x18 reads 64'h0.
